// File: rtl/alt_sync_ram_if.sv
// Port bundle for alt_sync_ram: address/data/control toward the RAM, read
// data back. The parameters must match the ones given to the RAM instance.
interface alt_sync_ram_if #(
  parameter int WIDTHAD       = 11,
  parameter int WIDTH         = 8,
  parameter int WIDTH_BYTEENA = 1
);
  logic [WIDTHAD-1:0]       address_a;
  logic [WIDTH-1:0]         data_a;
  logic                     wren_a;
  logic                     rden_a;
  logic [WIDTH_BYTEENA-1:0] byteena_a;
  logic                     addressstall_a;
  logic                     clocken0;
  logic [WIDTH-1:0]         q_a;

  // Side that issues accesses (pipeline / bench).
  modport master (
    output address_a, data_a, wren_a, rden_a, byteena_a, addressstall_a, clocken0,
    input  q_a
  );

  // The RAM itself.
  modport slave (
    input  address_a, data_a, wren_a, rden_a, byteena_a, addressstall_a, clocken0,
    output q_a
  );
endinterface

// File: rtl/alt_sync_ram.sv
// Single-port synchronous RAM with registered address, byte-masked writes,
// write-through on read-during-write and an optional output register.
// Character/data store for the display pipeline (normally read-only there).
// Requires NUMWORDS <= 2**WIDTHAD and WIDTHAD <= 32.
module alt_sync_ram #(
  parameter int WIDTHAD       = 11,
  parameter int WIDTH         = 8,
  parameter int NUMWORDS      = 1536,
  parameter int WIDTH_BYTEENA = 1,
  parameter int OUTDATA_REG   = 0,
  parameter int INIT_ZERO     = 1
) (
  input  logic          clock0,
  input  logic          sclr_n,
  alt_sync_ram_if.slave bus
);

  localparam logic [31:0] NUMWORDS_U = NUMWORDS;

  // Storage. With INIT_ZERO=0 the power-up contents are unspecified; all-ones
  // is used so a missing initialisation is easy to spot in simulation.
  logic [WIDTH-1:0] mem_q [NUMWORDS] = '{default: {WIDTH{(INIT_ZERO == 0)}}};

  logic [WIDTHAD-1:0] addr_q = '0;
  logic [WIDTHAD-1:0] addr_d;
  logic [WIDTH-1:0]   rd_q = '0;
  logic [WIDTH-1:0]   rd_d;
  logic [WIDTH-1:0]   out_q = '0;

  logic               in_range;
  logic               wr_en;
  logic [WIDTH-1:0]   be_mask;
  logic [WIDTH-1:0]   old_word;
  logic [WIDTH-1:0]   merged_word;

  // Expand the byte enables to one mask bit per data bit; the top byte may be
  // partial when WIDTH is not a multiple of 8.
  for (genvar b = 0; b < WIDTH; b++) begin : g_be_mask
    assign be_mask[b] = bus.byteena_a[b/8];
  end

  // Effective address, range check, merged write word and next read value.
  // The stall input reuses the latched address for this edge's access.
  always_comb begin
    addr_d      = bus.addressstall_a ? addr_q : bus.address_a;
    in_range    = (32'(addr_d) < NUMWORDS_U);
    old_word    = in_range ? mem_q[addr_d] : '0;
    merged_word = (bus.data_a & be_mask) | (old_word & ~be_mask);
    wr_en       = bus.clocken0 && bus.wren_a && in_range;
    rd_d        = rd_q;
    if (bus.wren_a) begin
      // write-through: the read register sees the merged word, rden ignored
      rd_d = in_range ? merged_word : '0;
    end else if (bus.rden_a) begin
      rd_d = in_range ? old_word : '0;
    end
  end

  // Memory write port; contents survive reset, but no write happens in reset.
  always_ff @(posedge clock0) begin
    if (sclr_n && wr_en) begin
      mem_q[addr_d] <= merged_word;
    end
  end

  // Address latch, read register and output register; reset beats clocken0.
  always_ff @(posedge clock0) begin
    if (!sclr_n) begin
      addr_q <= '0;
      rd_q   <= '0;
      out_q  <= '0;
    end else if (bus.clocken0) begin
      addr_q <= addr_d;
      rd_q   <= rd_d;
      out_q  <= rd_q;
    end
  end

  assign bus.q_a = (OUTDATA_REG != 0) ? out_q : rd_q;

endmodule

// File: tb/tb_alt_sync_ram.sv
// Bench for alt_sync_ram: an 8-bit unregistered-output instance and a 16-bit
// two-byte-enable registered-output instance driven with the same stimulus.
module tb_alt_sync_ram;

  localparam int NW = 1536;

  logic clk = 1'b0;
  logic sclr_n = 1'b0;
  always #5 clk = ~clk;

  alt_sync_ram_if #(.WIDTHAD(11), .WIDTH(8),  .WIDTH_BYTEENA(1)) bus8 ();
  alt_sync_ram_if #(.WIDTHAD(11), .WIDTH(16), .WIDTH_BYTEENA(2)) bus16 ();

  alt_sync_ram #(.WIDTHAD(11), .WIDTH(8), .NUMWORDS(NW), .WIDTH_BYTEENA(1),
                 .OUTDATA_REG(0), .INIT_ZERO(1))
    u_dut8 (.clock0(clk), .sclr_n(sclr_n), .bus(bus8));

  alt_sync_ram #(.WIDTHAD(11), .WIDTH(16), .NUMWORDS(NW), .WIDTH_BYTEENA(2),
                 .OUTDATA_REG(1), .INIT_ZERO(1))
    u_dut16 (.clock0(clk), .sclr_n(sclr_n), .bus(bus16));

  int errors = 0;
  int checks = 0;

  // Reference model: word arrays plus what each instance should be showing.
  logic [7:0]  m8  [NW];
  logic [15:0] m16 [NW];
  int          lat_a = 0;
  logic [7:0]  rd8 = '0;
  logic [15:0] rd16 = '0;
  logic [15:0] out16 = '0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One rising edge as seen from outside the RAM.
  task automatic model_edge(input logic rst, input logic ce, input logic [10:0] addr,
                            input logic [15:0] d, input logic we, input logic re,
                            input logic [1:0] be, input logic st);
    int a;
    if (!rst) begin
      rd8 = '0; rd16 = '0; out16 = '0; lat_a = 0;
    end else if (ce) begin
      a = st ? lat_a : int'(addr);
      lat_a = a;
      out16 = rd16;
      if (a < NW) begin
        if (we) begin
          if (be[0]) begin
            m8[a] = d[7:0];
            m16[a][7:0] = d[7:0];
          end
          if (be[1]) m16[a][15:8] = d[15:8];
        end
        if (we || re) begin
          rd8 = m8[a];
          rd16 = m16[a];
        end
      end else if (we || re) begin
        rd8 = '0;
        rd16 = '0;
      end
    end
  endtask

  task automatic step(input logic rst, input logic ce, input logic [10:0] addr,
                      input logic [15:0] d, input logic we, input logic re,
                      input logic [1:0] be, input logic st);
    sclr_n = rst;
    bus8.clocken0 = ce;        bus16.clocken0 = ce;
    bus8.address_a = addr;     bus16.address_a = addr;
    bus8.data_a = d[7:0];      bus16.data_a = d;
    bus8.wren_a = we;          bus16.wren_a = we;
    bus8.rden_a = re;          bus16.rden_a = re;
    bus8.byteena_a = be[0];    bus16.byteena_a = be;
    bus8.addressstall_a = st;  bus16.addressstall_a = st;
    @(posedge clk);
    #1;
    model_edge(rst, ce, addr, d, we, re, be, st);
    check("q8_model", {8'h00, bus8.q_a}, {8'h00, rd8});
    check("q16_model", bus16.q_a, out16);
  endtask

  typedef struct {
    logic        rst;
    logic        ce;
    logic [10:0] addr;
    logic [15:0] d;
    logic        we;
    logic        re;
    logic [1:0]  be;
    logic        st;
    logic [7:0]  exp8;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst, input logic ce, input int addr, input logic [15:0] d,
                             input logic we, input logic re, input logic st, input logic [7:0] exp8);
    vec_t r;
    r.rst = rst; r.ce = ce; r.addr = 11'(addr); r.d = d; r.we = we; r.re = re;
    r.be = 2'b11; r.st = st; r.exp8 = exp8;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < NW; i++) begin
      m8[i] = '0;
      m16[i] = '0;
    end
    sclr_n = 1'b0;
    bus8.clocken0 = 1'b1;  bus16.clocken0 = 1'b1;
    bus8.address_a = '0;   bus16.address_a = '0;
    bus8.data_a = '0;      bus16.data_a = '0;
    bus8.wren_a = 1'b0;    bus16.wren_a = 1'b0;
    bus8.rden_a = 1'b0;    bus16.rden_a = 1'b0;
    bus8.byteena_a = '1;   bus16.byteena_a = '1;
    bus8.addressstall_a = 1'b0; bus16.addressstall_a = 1'b0;

    //             rst ce  addr  data     we re st  exp8
    tbl.push_back(v(0, 1, 5,    16'h0000, 0, 1, 0, 8'h00)); // reset, q=0
    tbl.push_back(v(0, 1, 5,    16'h0000, 0, 1, 0, 8'h00));
    tbl.push_back(v(1, 1, 5,    16'h0000, 0, 1, 0, 8'h00)); // word[5] power-up 0
    tbl.push_back(v(1, 1, 0,    16'h0041, 1, 0, 0, 8'h41)); // write-through
    tbl.push_back(v(1, 1, 1535, 16'h005A, 1, 0, 0, 8'h5A));
    tbl.push_back(v(1, 1, 0,    16'h0000, 0, 1, 0, 8'h41));
    tbl.push_back(v(1, 1, 1535, 16'h0000, 0, 1, 0, 8'h5A));
    tbl.push_back(v(1, 1, 7,    16'h0011, 1, 0, 0, 8'h11));
    tbl.push_back(v(1, 1, 7,    16'h0022, 1, 1, 0, 8'h22)); // read-during-write
    tbl.push_back(v(1, 1, 0,    16'h0000, 0, 1, 0, 8'h41));
    tbl.push_back(v(1, 1, 7,    16'h0000, 0, 1, 0, 8'h22));
    tbl.push_back(v(1, 1, 0,    16'h0000, 0, 1, 0, 8'h41));
    tbl.push_back(v(1, 1, 1,    16'h0000, 0, 0, 0, 8'h41)); // rden=0 holds
    tbl.push_back(v(1, 1, 1,    16'h0000, 0, 0, 0, 8'h41));
    tbl.push_back(v(1, 1, 1,    16'h0000, 0, 0, 0, 8'h41));
    tbl.push_back(v(1, 0, 1,    16'h0000, 0, 1, 0, 8'h41)); // clocken0=0 holds
    tbl.push_back(v(1, 0, 0,    16'h0099, 1, 1, 0, 8'h41)); // gated write
    tbl.push_back(v(1, 1, 0,    16'h0000, 0, 1, 0, 8'h41)); // word 0 unchanged
    tbl.push_back(v(1, 1, 1535, 16'h0000, 0, 1, 1, 8'h41)); // stall keeps addr 0
    tbl.push_back(v(1, 1, 1535, 16'h0000, 0, 1, 1, 8'h41));
    tbl.push_back(v(1, 1, 1600, 16'h0000, 0, 1, 0, 8'h00)); // out of range read
    tbl.push_back(v(1, 1, 1535, 16'h0000, 0, 1, 0, 8'h5A));
    tbl.push_back(v(1, 1, 1600, 16'h00FF, 1, 0, 0, 8'h00)); // out of range write
    tbl.push_back(v(1, 1, 1535, 16'h0000, 0, 1, 0, 8'h5A));
    tbl.push_back(v(0, 1, 0,    16'h0077, 1, 1, 0, 8'h00)); // no write in reset
    tbl.push_back(v(1, 1, 0,    16'h0000, 0, 1, 0, 8'h41));
    tbl.push_back(v(0, 0, 9,    16'h0000, 0, 1, 0, 8'h00)); // reset beats clocken0
    tbl.push_back(v(1, 1, 1535, 16'h0000, 0, 1, 1, 8'h41)); // latched addr was cleared

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].ce, tbl[i].addr, tbl[i].d, tbl[i].we, tbl[i].re, tbl[i].be, tbl[i].st);
      check($sformatf("vec%0d_q8", i), {8'h00, bus8.q_a}, {8'h00, tbl[i].exp8});
    end

    // Byte enable and two-cycle latency on the 16-bit registered instance.
    step(1, 1, 3, 16'h1234, 1, 0, 2'b11, 0);
    step(1, 1, 3, 16'hABCD, 1, 0, 2'b01, 0);
    step(1, 1, 0, 16'h0000, 0, 1, 2'b00, 0);
    step(1, 1, 3, 16'h0000, 0, 1, 2'b00, 0);
    check("be16_one_cycle_after", bus16.q_a, 16'h0041);
    step(1, 1, 5, 16'h0000, 0, 0, 2'b00, 0);
    check("be16_two_cycles_after", bus16.q_a, 16'h12CD);
    step(1, 1, 5, 16'h0000, 0, 0, 2'b00, 0);
    check("be16_hold", bus16.q_a, 16'h12CD);
    check("be8_word3", {8'h00, bus8.q_a}, 16'h00CD);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int sel;
      int a;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)       a = int'($urandom_range(0, 15));
      else if (sel < 8)  a = int'($urandom_range(1528, 1543));
      else               a = int'($urandom_range(0, 2047));
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 6) != 0), 11'(a),
           16'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom), ($urandom_range(0, 4) == 0));
    end

    // Sweep every word: nothing outside the model's writes may have changed.
    for (int i = 0; i < NW; i++) begin
      step(1, 1, 11'(i), 16'h0000, 0, 1, 2'b00, 0);
    end
    step(1, 1, 0, 16'h0000, 0, 0, 2'b00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
